// File: rtl/ber_if.sv
// Bus bundle for ber_counter: control and bit-stream inputs, count/lock outputs.
//   master : drives soft_reset, enable, valid, ref_bit, rx_bit; observes results
//   slave  : the checker side (ber_counter)
interface ber_if #(
   parameter int unsigned DELAY_LEN     = 512,
   parameter int unsigned LOG_COUNT_LEN = 64
);
   localparam int unsigned SEL_W = (DELAY_LEN > 1) ? $clog2(DELAY_LEN) : 1;

   logic                     soft_reset;
   logic                     enable;
   logic                     valid;
   logic                     ref_bit;
   logic                     rx_bit;
   logic [LOG_COUNT_LEN-1:0] error_count;
   logic [LOG_COUNT_LEN-1:0] bit_count;
   logic                     locked;
   logic [SEL_W-1:0]         delay_sel;

   modport master (
      output soft_reset, enable, valid, ref_bit, rx_bit,
      input  error_count, bit_count, locked, delay_sel
   );

   modport slave (
      input  soft_reset, enable, valid, ref_bit, rx_bit,
      output error_count, bit_count, locked, delay_sel
   );
endinterface

// File: rtl/ber_counter.sv
// Bit-error-rate checker for one I/Q branch. Aligns rx_bit against a delayed
// copy of ref_bit (search over delay taps), then counts compared bits and errors.
// Ports:
//   clk, rst           : clock, asynchronous active-high reset
//   bus (ber_if.slave) : soft_reset, enable, valid, ref_bit, rx_bit in;
//                        error_count, bit_count, locked, delay_sel out (registered)
// Optional: define BER_RESYNC_EN to add a loss-of-lock monitor in COUNT that
// returns to SEARCH at the next tap when a window exceeds SYNC_WINDOW/4 errors.
module ber_counter #(
   parameter int unsigned DELAY_LEN     = 512,
   parameter int unsigned SYNC_WINDOW   = 511,
   parameter int unsigned SYNC_THRESH   = 0,
   parameter int unsigned LOG_COUNT_LEN = 64
) (
   input  logic clk,
   input  logic rst,
   ber_if.slave bus
);
   localparam int unsigned SEL_W = (DELAY_LEN > 1) ? $clog2(DELAY_LEN) : 1;
   localparam int unsigned WIN_W = $clog2(SYNC_WINDOW + 1);
`ifdef BER_RESYNC_EN
   localparam int unsigned LOSS_THRESH = SYNC_WINDOW / 4;
`endif

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SEARCH = 2'd1,
      COUNT  = 2'd2
   } state_e;

   state_e                   state_q, state_d;
   logic [DELAY_LEN-1:0]     line_q, line_d;
   logic [SEL_W-1:0]         delay_sel_q, delay_sel_d;
   logic [WIN_W-1:0]         win_bits_q, win_bits_d;
   logic [WIN_W-1:0]         win_errs_q, win_errs_d;
   logic [LOG_COUNT_LEN-1:0] error_count_q, error_count_d;
   logic [LOG_COUNT_LEN-1:0] bit_count_q, bit_count_d;
   logic                     locked_q, locked_d;

   logic                     mismatch;
   logic [WIN_W-1:0]         win_bits_inc;
   logic [WIN_W-1:0]         win_errs_inc;
   logic                     window_done;
   logic [SEL_W-1:0]         sel_next;

   // State and datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         line_q        <= '0;
         delay_sel_q   <= '0;
         win_bits_q    <= '0;
         win_errs_q    <= '0;
         error_count_q <= '0;
         bit_count_q   <= '0;
         locked_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         line_q        <= line_d;
         delay_sel_q   <= delay_sel_d;
         win_bits_q    <= win_bits_d;
         win_errs_q    <= win_errs_d;
         error_count_q <= error_count_d;
         bit_count_q   <= bit_count_d;
         locked_q      <= locked_d;
      end
   end

   // Next-state, window and counter logic
   always_comb begin
      state_d       = state_q;
      line_d        = line_q;
      delay_sel_d   = delay_sel_q;
      win_bits_d    = win_bits_q;
      win_errs_d    = win_errs_q;
      error_count_d = error_count_q;
      bit_count_d   = bit_count_q;
      locked_d      = 1'b0;

      // Compare uses the line contents before this cycle's shift
      mismatch     = bus.rx_bit ^ line_q[delay_sel_q];
      win_bits_inc = win_bits_q + WIN_W'(1);
      win_errs_inc = win_errs_q + WIN_W'(mismatch);
      window_done  = (win_bits_inc == WIN_W'(SYNC_WINDOW));
      sel_next     = (delay_sel_q == SEL_W'(DELAY_LEN - 1)) ? '0 : delay_sel_q + SEL_W'(1);

      // tap[0] is the newest reference bit; shifts in every state
      if (bus.valid) begin
         line_d = {line_q[DELAY_LEN-2:0], bus.ref_bit};
      end

      case (state_q)
         IDLE: begin
            if (bus.enable) begin
               state_d    = SEARCH;
               win_bits_d = '0;
               win_errs_d = '0;
            end
         end
         SEARCH: begin
            if (!bus.enable) begin
               state_d = IDLE;
            end else if (bus.valid) begin
               if (window_done) begin
                  win_bits_d = '0;
                  win_errs_d = '0;
                  if (win_errs_inc <= WIN_W'(SYNC_THRESH)) begin
                     state_d = COUNT;
                  end else begin
                     delay_sel_d = sel_next;
                  end
               end else begin
                  win_bits_d = win_bits_inc;
                  win_errs_d = win_errs_inc;
               end
            end
         end
         COUNT: begin
            if (!bus.enable) begin
               state_d = IDLE;
            end else if (bus.valid) begin
               // A saturated bit_count freezes error_count too, keeping the ratio sane
               if (!(&bit_count_q)) begin
                  bit_count_d = bit_count_q + LOG_COUNT_LEN'(1);
                  if (mismatch && !(&error_count_q)) begin
                     error_count_d = error_count_q + LOG_COUNT_LEN'(1);
                  end
               end
`ifdef BER_RESYNC_EN
               // Loss monitor: too many errors in one window means alignment was lost
               if (window_done) begin
                  win_bits_d = '0;
                  win_errs_d = '0;
                  if (win_errs_inc > WIN_W'(LOSS_THRESH)) begin
                     state_d     = SEARCH;
                     delay_sel_d = sel_next;
                  end
               end else begin
                  win_bits_d = win_bits_inc;
                  win_errs_d = win_errs_inc;
               end
`endif
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Synchronous clear overrides everything above
      if (bus.soft_reset) begin
         state_d       = IDLE;
         line_d        = '0;
         delay_sel_d   = '0;
         win_bits_d    = '0;
         win_errs_d    = '0;
         error_count_d = '0;
         bit_count_d   = '0;
      end

      locked_d = (state_d == COUNT);
   end

   assign bus.error_count = error_count_q;
   assign bus.bit_count   = bit_count_q;
   assign bus.locked      = locked_q;
   assign bus.delay_sel   = delay_sel_q;
endmodule

// File: tb/tb_ber_counter.sv
// Directed bench for ber_counter: two instances (64-bit and 8-bit counters)
// share one PRBS9 stream; rx_bit is reference history tap rx_delay.
module tb_ber_counter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic soft_reset = 1'b0;
   logic enable = 1'b0;
   logic valid = 1'b0;
   logic ref_bit = 1'b0;
   logic rx_bit = 1'b0;

   int errors = 0;
   int checks = 0;

   logic [8:0]  prbs = 9'h1FF;
   logic [31:0] hist = '0;
   int          rx_delay = 5;
   bit          saw_locked = 1'b0;
   int          wraps = 0;
   logic [3:0]  prev_sel = '0;

   always #5 clk = ~clk;

   ber_if #(.DELAY_LEN(16), .LOG_COUNT_LEN(64)) bif ();
   ber_if #(.DELAY_LEN(16), .LOG_COUNT_LEN(8))  bif8 ();

   assign bif.soft_reset  = soft_reset;
   assign bif.enable      = enable;
   assign bif.valid       = valid;
   assign bif.ref_bit     = ref_bit;
   assign bif.rx_bit      = rx_bit;
   assign bif8.soft_reset = soft_reset;
   assign bif8.enable     = enable;
   assign bif8.valid      = valid;
   assign bif8.ref_bit    = ref_bit;
   assign bif8.rx_bit     = rx_bit;

   ber_counter #(.DELAY_LEN(16), .SYNC_WINDOW(32), .SYNC_THRESH(0), .LOG_COUNT_LEN(64)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bif.slave)
   );

   ber_counter #(.DELAY_LEN(16), .SYNC_WINDOW(32), .SYNC_THRESH(0), .LOG_COUNT_LEN(8)) dut8 (
      .clk (clk),
      .rst (rst),
      .bus (bif8.slave)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // One clock: drive at negedge, advance the reference model after posedge
   task automatic tick(input logic v, input logic inv);
      @(negedge clk);
      valid   = v;
      ref_bit = prbs[8];
      rx_bit  = hist[rx_delay] ^ inv;
      @(posedge clk);
      if (v) begin
         hist = {hist[30:0], ref_bit};
         prbs = {prbs[7:0], prbs[8] ^ prbs[4]};
      end
      #1;
      if (bif.locked) saw_locked = 1'b1;
      if (prev_sel == 4'd15 && bif.delay_sel == 4'd0) wraps++;
      prev_sel = bif.delay_sel;
   endtask

   task automatic run(input int n, input int inv_every, input bit gaps);
      for (int i = 1; i <= n; i++) begin
         if (gaps && (i % 3 == 0)) tick(1'b0, 1'b0);
         tick(1'b1, (inv_every != 0) && (i % inv_every == 0));
      end
   endtask

   task automatic pulse_soft_reset();
      soft_reset = 1'b1;
      tick(1'b1, 1'b0);
      soft_reset = 1'b0;
   endtask

   initial begin
      // Reset state
      repeat (3) tick(1'b0, 1'b0);
      check("rst_err", bif.error_count, 64'd0);
      check("rst_bits", bif.bit_count, 64'd0);
      check("rst_locked", 64'(bif.locked), 64'd0);
      check("rst_sel", 64'(bif.delay_sel), 64'd0);
      rst = 1'b0;

      // IDLE: line fills but nothing else moves
      rx_delay = 5;
      run(10, 0, 1'b0);
      check("idle_locked", 64'(bif.locked), 64'd0);
      check("idle_sel", 64'(bif.delay_sel), 64'd0);

      // Search: six 32-bit windows, lock on the 192nd valid at tap 5
      enable = 1'b1;
      tick(1'b0, 1'b0);
      run(191, 0, 1'b1);
      check("pre_lock_locked", 64'(bif.locked), 64'd0);
      check("pre_lock_sel", 64'(bif.delay_sel), 64'd5);
      run(1, 0, 1'b0);
      check("lock_locked", 64'(bif.locked), 64'd1);
      check("lock_sel", 64'(bif.delay_sel), 64'd5);
      check("lock_bits", bif.bit_count, 64'd0);
      check("lock8_locked", 64'(bif8.locked), 64'd1);

      // Error-free counting; 8-bit instance saturates at 255
      run(200, 0, 1'b0);
      check("c200_bits8", 64'(bif8.bit_count), 64'd200);
      run(800, 0, 1'b0);
      check("c1000_bits", bif.bit_count, 64'd1000);
      check("c1000_errs", bif.error_count, 64'd0);
      check("sat_bits8", 64'(bif8.bit_count), 64'd255);
      check("sat_errs8", 64'(bif8.error_count), 64'd0);

      // Every 100th bit inverted: 10 errors in 1000; saturated counter ignores them
      run(1000, 100, 1'b0);
      check("inj_errs", bif.error_count, 64'd10);
      check("inj_bits", bif.bit_count, 64'd2000);
      check("inj_errs8", 64'(bif8.error_count), 64'd0);
      check("inj_bits8", 64'(bif8.bit_count), 64'd255);

      // Disable: locked drops, counts and tap held
      enable = 1'b0;
      tick(1'b0, 1'b0);
      run(5, 1, 1'b0);
      check("dis_locked", 64'(bif.locked), 64'd0);
      check("dis_bits", bif.bit_count, 64'd2000);
      check("dis_errs", bif.error_count, 64'd10);
      check("dis_sel", 64'(bif.delay_sel), 64'd5);

      // Re-enable: search resumes at held tap and locks in one window
      enable = 1'b1;
      tick(1'b0, 1'b0);
      run(31, 0, 1'b0);
      check("reen_pre_locked", 64'(bif.locked), 64'd0);
      run(1, 0, 1'b0);
      check("reen_locked", 64'(bif.locked), 64'd1);
      check("reen_bits", bif.bit_count, 64'd2000);

      // Soft reset while locked (valid high on that edge)
      pulse_soft_reset();
      check("srst_bits", bif.bit_count, 64'd0);
      check("srst_errs", bif.error_count, 64'd0);
      check("srst_locked", 64'(bif.locked), 64'd0);
      check("srst_sel", 64'(bif.delay_sel), 64'd0);
      check("srst_bits8", 64'(bif8.bit_count), 64'd0);
      tick(1'b0, 1'b0);
      run(191, 0, 1'b0);
      check("relock_pre", 64'(bif.locked), 64'd0);
      run(1, 0, 1'b0);
      check("relock_locked", 64'(bif.locked), 64'd1);
      check("relock_sel", 64'(bif.delay_sel), 64'd5);

      // Delay outside search range: never locks, tap wraps repeatedly
      pulse_soft_reset();
      rx_delay   = 20;
      saw_locked = 1'b0;
      wraps      = 0;
      run(1064, 0, 1'b0);
      check("far_never_locked", 64'(saw_locked), 64'd0);
      check("far_wraps_ge2", 64'(wraps >= 2), 64'd1);
      check("far_bits", bif.bit_count, 64'd0);
      check("far_errs", bif.error_count, 64'd0);

`ifdef BER_RESYNC_EN
      begin
         logic [63:0] held_bits;
         bit          dropped;
         bit          relocked;
         pulse_soft_reset();
         rx_delay = 5;
         tick(1'b0, 1'b0);
         run(192, 0, 1'b0);
         check("rs_lock", 64'(bif.locked), 64'd1);
         run(100, 0, 1'b0);
         held_bits = bif.bit_count;
         rx_delay  = 9;
         dropped   = 1'b0;
         for (int i = 0; i < 64 && !dropped; i++) begin
            run(1, 0, 1'b0);
            if (!bif.locked) dropped = 1'b1;
         end
         check("rs_dropped", 64'(dropped), 64'd1);
         relocked = 1'b0;
         for (int i = 0; i < 200 && !relocked; i++) begin
            run(1, 0, 1'b0);
            if (bif.locked) relocked = 1'b1;
         end
         check("rs_relocked", 64'(relocked), 64'd1);
         check("rs_sel", 64'(bif.delay_sel), 64'd9);
         check("rs_bits_held", 64'(bif.bit_count >= held_bits), 64'd1);
      end
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/ber_counter.md
Name: ber_counter

Overview:
- Bit-error-rate checker for one I or Q branch, on the receive side of the DSP chain.
- Aligns the received bit stream to a delayed copy of the transmitted reference stream, then counts compared bits and errors.
- Its 64-bit count outputs feed error_count_r/_i and bit_count_r/_i of the control register file.
- Its soft_reset and enable inputs are driven by that register file's reset_reg and enable_reg[2] (ber).

Parameters:
- DELAY_LEN, 512: depth of the reference delay line; alignment search range 0..DELAY_LEN-1.
- SYNC_WINDOW, 511: number of valid bits compared per alignment trial.
- SYNC_THRESH, 0: maximum errors in a trial window for that trial to count as locked.
- LOG_COUNT_LEN, 64: width of the error and bit counters.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-high reset
- soft_reset  input  1  synchronous clear, level-sensitive (from reset_reg)
- enable  input  1  BER enable (from enable_reg[2])
- valid  input  1  symbol strobe; ref_bit and rx_bit sampled only when high
- ref_bit  input  1  transmitted reference bit
- rx_bit  input  1  received decision bit
- error_count  output  LOG_COUNT_LEN  accumulated errors while locked
- bit_count  output  LOG_COUNT_LEN  accumulated compared bits while locked
- locked  output  1  high in COUNT state
- delay_sel  output  clog2(DELAY_LEN)  current alignment tap

Behaviour:
- Reset: rst is asynchronous and active-high. It clears every register immediately: error_count=0, bit_count=0, locked=0, delay_sel=0, delay line all 0, window counters 0, state=IDLE.
- soft_reset=1 (synchronous): same clears as rst on the next edge; it has priority over all other inputs, and the state is held in IDLE while soft_reset is high.
- Delay line: a DELAY_LEN-bit shift register that shifts in ref_bit on every valid, in every state including IDLE. The compared reference bit is tap[delay_sel], where tap[0] is the most recently shifted bit.
- mismatch = rx_bit XOR tap[delay_sel], evaluated with the line contents before this cycle's shift.
- FSM:
  - IDLE: on enable=1, go to SEARCH and clear win_bits and win_errs.
  - SEARCH: each valid does win_bits++ and win_errs += mismatch. When the SYNC_WINDOW-th bit of the window is processed:
    - if final win_errs <= SYNC_THRESH, go to COUNT and assert locked on that edge;
    - otherwise delay_sel++ (wrapping DELAY_LEN-1 -> 0) and clear both window counters.
    - The search never terminates on its own; it wraps indefinitely.
  - COUNT: each valid does bit_count++ and error_count += mismatch. Bits from the locking window are not counted.
  - Any state with enable=0: go to IDLE and clear locked. error_count, bit_count and delay_sel hold their values. On re-enable, the search restarts from the held delay_sel.
- Saturation: the counters saturate at all-ones and never wrap. If bit_count is saturated, error_count also stops incrementing, so the ratio stays consistent.
- Latency: outputs are registered. A valid sampled on edge N is reflected in the counts after edge N.
- Simultaneous events: soft_reset beats enable transitions. enable=0 on the same edge as a lock decision gives IDLE with locked=0.
- valid=0 cycles: no state advance and no count change.

Optional Feature:
- Macro: BER_RESYNC_EN.
- Defined:
  - In COUNT, a loss monitor tracks errors over consecutive SYNC_WINDOW-bit windows.
  - If errors in one window exceed SYNC_WINDOW/4, return to SEARCH at delay_sel+1 (with wrap) and deassert locked.
  - error_count and bit_count hold and are not cleared.
- Undefined: COUNT is left only via enable=0, soft_reset or rst; there is no loss monitor logic.

Test Plan:
- DELAY_LEN=16, SYNC_WINDOW=32, rx_bit = ref_bit delayed 5 valids, PRBS9, enable=1 -> locked rises after 6 windows (192 valids), delay_sel=5; after 1000 further valids bit_count=1000, error_count=0.
- Same setup, force rx_bit inverted on every 100th valid after lock -> after 1000 valids error_count=10, bit_count=1000.
- Assert soft_reset for 1 cycle while locked -> next edge: counts 0, locked=0, delay_sel=0, state IDLE; re-lock with the same timing as scenario 1.
- rx_bit delay 20 (beyond DELAY_LEN=16) -> locked never asserts; delay_sel wraps 15 -> 0 at least twice; counts stay 0.
- Preload counters near saturation (LOG_COUNT_LEN=8), error-free stream -> bit_count stops at 255 and error_count stops changing.
- BER_RESYNC_EN defined: shift the rx delay from 5 to 9 mid-COUNT -> locked drops within one window, re-locks at delay_sel=9, and counts held across the resync.
